// File: rtl/mac_gs_pkg.sv
// rtl/mac_gs_pkg.sv - shared jump codes, fetch FSM states and instruction field helpers
package mac_gs_pkg;

  localparam logic [2:0] JC_IDLE = 3'd0;
  localparam logic [2:0] JC_EQZ  = 3'd1;
  localparam logic [2:0] JC_NEZ  = 3'd2;
  localparam logic [2:0] JC_TEQZ = 3'd3;
  localparam logic [2:0] JC_TNEZ = 3'd4;
  localparam logic [2:0] JC_JUMP = 3'd5;
  localparam logic [2:0] JC_DB   = 3'd6;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Immediate field positions: conditional branches use [7:0], DB uses [10:0]
  localparam int BR_OFF_MSB = 7;
  localparam int DB_OFF_MSB = 10;

  typedef enum logic [1:0] {
    ST_RST_WAIT,
    ST_FETCH,
    ST_ISSUE,
    ST_RESOLVE
  } fetch_state_t;

  function automatic logic [15:0] sext_br(input logic [15:0] instr);
    return {{(15 - BR_OFF_MSB){instr[BR_OFF_MSB]}}, instr[BR_OFF_MSB:0]};
  endfunction

  function automatic logic [15:0] sext_db(input logic [15:0] instr);
    return {{(15 - DB_OFF_MSB){instr[DB_OFF_MSB]}}, instr[DB_OFF_MSB:0]};
  endfunction

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational next-PC selection from the decoder's jump control
module branch_target
  import mac_gs_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic [2:0]  jumpControl,
  input  logic [15:0] reg_operand,
  input  logic        t_flag,
  output logic [15:0] next_pc
);

  logic [15:0] seq;
  logic [15:0] br_target;
  logic [15:0] db_target;
  logic        reg_zero;

  assign seq       = pc + 16'd1;
  assign br_target = seq + sext_br(instr);
  assign db_target = seq + sext_db(instr);
  assign reg_zero  = (reg_operand == 16'h0000);

  // Pick the next PC; unknown code 7 falls through to sequential like IDLE
  always_comb begin
    next_pc = seq;
    case (jumpControl)
      JC_EQZ:  next_pc = reg_zero ? br_target : seq;
      JC_NEZ:  next_pc = reg_zero ? seq : br_target;
      JC_TEQZ: next_pc = t_flag ? seq : br_target;
      JC_TNEZ: next_pc = t_flag ? br_target : seq;
      JC_JUMP: next_pc = reg_operand;
      JC_DB:   next_pc = db_target;
      default: next_pc = seq;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - multi-cycle fetch FSM and PC owner feeding the instruction decoder
module instruction_fetch
  import mac_gs_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  input  logic        stall,
  input  logic [2:0]  jumpControl,
  input  logic [15:0] reg_operand,
  input  logic        t_flag
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  instr_q;
  logic [15:0]  pc_q;
  logic         req_q;
  logic         valid_q;
  logic [15:0]  next_pc;

  branch_target u_branch_target (
    .pc          (pc),
    .instr       (instr_q),
    .jumpControl (jumpControl),
    .reg_operand (reg_operand),
    .t_flag      (t_flag),
    .next_pc     (next_pc)
  );

  // pc only moves in RESOLVE, so the address is stable for the whole request
  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;

  // Fetch sequencer: the instruction register only loads on FETCH->ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RST_WAIT;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_RST_WAIT: begin
          req_q <= 1'b1;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            pc_q    <= pc;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            valid_q <= 1'b0;
            state   <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          pc    <= next_pc;
          req_q <= 1'b1;
          state <= ST_FETCH;
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= ST_RST_WAIT;
        end
      endcase
    end
  end

endmodule
